// File: rtl/fp_pkg.sv
// Shared encodings for the pipelined FP units: rounding modes, flag bit positions,
// operand classes and the rounding-increment decision.
package fp_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RUP = 2'd2,
    RM_RDN = 2'd3
  } rm_e;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;
  localparam int FLG_W   = 4;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  function automatic fp_class_e fp_classify(input logic exp_ones, input logic exp_zero,
                                            input logic frac_zero);
    if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
    if (exp_zero) return frac_zero ? CLS_ZERO : CLS_SUB;
    return CLS_NORM;
  endfunction

  function automatic logic round_inc(input rm_e mode, input logic sign, input logic guard,
                                     input logic sticky, input logic lsb);
    case (mode)
      RM_RNE:  return guard & (sticky | lsb);
      RM_RTZ:  return 1'b0;
      RM_RUP:  return (guard | sticky) & ~sign;
      default: return (guard | sticky) & sign;
    endcase
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round, overflow/underflow resolve and pack a raw significand product.
// Purely combinational; timing and flow control belong to the instantiating pipeline.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   sign,
  input  logic [EXP_W+1:0]       exp_in,
  input  logic [2*MAN_W+1:0]     sig,
  input  logic [1:0]             rm,
  output logic [EXP_W+MAN_W:0]   z,
  output logic [FLG_W-1:0]       flags
);

  localparam int SIG_W = 2*MAN_W + 2;
  localparam logic [EXP_W+1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [EXP_W+1:0] EXP_ONE = {{(EXP_W+1){1'b0}}, 1'b1};

  rm_e                mode;
  logic [SIG_W-1:0]   norm;
  logic [EXP_W+1:0]   exp_n;
  logic [EXP_W+1:0]   exp_r;
  logic [MAN_W:0]     mant;
  logic [MAN_W+1:0]   mant_r;
  logic [MAN_W-1:0]   frac;
  logic               guard;
  logic               sticky;
  logic               inc;
  logic               ovf;
  logic               unf;
  logic               to_inf;

  always_comb begin
    mode = rm_e'(rm);

    // Product of two 1.x significands lies in [1,4); bring the leading one to the MSB.
    norm  = sig[SIG_W-1] ? sig : {sig[SIG_W-2:0], 1'b0};
    exp_n = exp_in + {{(EXP_W+1){1'b0}}, sig[SIG_W-1]};

    mant   = norm[SIG_W-1:MAN_W+1];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];

    inc    = round_inc(mode, sign, guard, sticky, mant[0]);
    mant_r = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    exp_r  = exp_n + {{(EXP_W+1){1'b0}}, mant_r[MAN_W+1]};
    frac   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

    ovf    = $signed(exp_r) >= $signed(EXP_MAX);
    unf    = $signed(exp_r) <  $signed(EXP_ONE);
    to_inf = (mode == RM_RNE) | ((mode == RM_RUP) & ~sign) | ((mode == RM_RDN) & sign);

    z              = {sign, exp_r[EXP_W-1:0], frac};
    flags          = '0;
    flags[FLG_INX] = guard | sticky;

    if (ovf) begin
      z = to_inf ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                 : {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      flags[FLG_OVF] = 1'b1;
      flags[FLG_INX] = 1'b1;
    end else if (unf) begin
      z = {sign, {(EXP_W+MAN_W){1'b0}}};
      flags[FLG_UNF] = 1'b1;
      flags[FLG_INX] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage IEEE-754-style multiplier (classify, multiply, round/pack), 3-cycle latency.
// Valid/ready throughout; a stalled output freezes every full stage and drops in_ready.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [1:0]           rm,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] z,
  output logic [FLG_W-1:0]     flags,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = 2*MAN_W + 2;
  localparam logic [EXP_W+1:0] BIAS = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [W-1:0]     QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic               sign;
    logic [EXP_W-1:0]   ea;
    logic [EXP_W-1:0]   eb;
    logic [MAN_W:0]     ma;
    logic [MAN_W:0]     mb;
    logic [1:0]         rm;
    logic [TAG_W-1:0]   tag;
    logic               special;
    logic [W-1:0]       spec_z;
    logic [FLG_W-1:0]   spec_flg;
  } s1_t;

  typedef struct packed {
    logic               sign;
    logic [EXP_W+1:0]   exp;
    logic [SIG_W-1:0]   prod;
    logic [1:0]         rm;
    logic [TAG_W-1:0]   tag;
    logic               special;
    logic [W-1:0]       spec_z;
    logic [FLG_W-1:0]   spec_flg;
  } s2_t;

  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic             v1, v2, v3;
  logic             ld2, ld3;
  fp_class_e        cls_a, cls_b;
  logic             zero_a, zero_b;
  logic             nan_any, inf_any, zero_any;
  logic [W-1:0]     rp_z;
  logic [FLG_W-1:0] rp_flg;

  assign ld3       = ~v3 | out_ready;
  assign ld2       = ~v2 | ld3;
  assign in_ready  = ~v1 | ld2;
  assign out_valid = v3;

  // Stage 1: classify; subnormals count as zero, specials are resolved here and ride along.
  always_comb begin
    cls_a    = fp_classify(&a[W-2:MAN_W], ~|a[W-2:MAN_W], ~|a[MAN_W-1:0]);
    cls_b    = fp_classify(&b[W-2:MAN_W], ~|b[W-2:MAN_W], ~|b[MAN_W-1:0]);
    zero_a   = (cls_a == CLS_ZERO) | (cls_a == CLS_SUB);
    zero_b   = (cls_b == CLS_ZERO) | (cls_b == CLS_SUB);
    nan_any  = (cls_a == CLS_NAN) | (cls_b == CLS_NAN);
    inf_any  = (cls_a == CLS_INF) | (cls_b == CLS_INF);
    zero_any = zero_a | zero_b;

    s1_d          = '0;
    s1_d.sign     = a[W-1] ^ b[W-1];
    s1_d.ea       = a[W-2:MAN_W];
    s1_d.eb       = b[W-2:MAN_W];
    s1_d.ma       = {1'b1, a[MAN_W-1:0]};
    s1_d.mb       = {1'b1, b[MAN_W-1:0]};
    s1_d.rm       = rm;
    s1_d.tag      = in_tag;
    s1_d.special  = nan_any | inf_any | zero_any;

    if (nan_any | (inf_any & zero_any)) begin
      s1_d.spec_z            = QNAN;
      s1_d.spec_flg[FLG_INV] = 1'b1;
    end else if (inf_any) begin
      s1_d.spec_z = {s1_d.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_any) begin
      s1_d.spec_z = {s1_d.sign, {(EXP_W+MAN_W){1'b0}}};
    end
  end

  // Stage 2: full significand product and a signed biased exponent with headroom.
  always_comb begin
    s2_d          = '0;
    s2_d.sign     = s1_q.sign;
    s2_d.exp      = {2'b00, s1_q.ea} + {2'b00, s1_q.eb} - BIAS;
    s2_d.prod     = {{(MAN_W+1){1'b0}}, s1_q.ma} * {{(MAN_W+1){1'b0}}, s1_q.mb};
    s2_d.rm       = s1_q.rm;
    s2_d.tag      = s1_q.tag;
    s2_d.special  = s1_q.special;
    s2_d.spec_z   = s1_q.spec_z;
    s2_d.spec_flg = s1_q.spec_flg;
  end

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign   (s2_q.sign),
    .exp_in (s2_q.exp),
    .sig    (s2_q.prod),
    .rm     (s2_q.rm),
    .z      (rp_z),
    .flags  (rp_flg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      z       <= '0;
      flags   <= '0;
      out_tag <= '0;
    end else begin
      if (in_ready) v1 <= in_valid;
      if (ld2)      v2 <= v1;
      if (ld3)      v3 <= v2;

      if (in_valid & in_ready) s1_q <= s1_d;
      if (ld2 & v1)            s2_q <= s2_d;
      if (ld3 & v2) begin
        z       <= s2_q.special ? s2_q.spec_z   : rp_z;
        flags   <= s2_q.special ? s2_q.spec_flg : rp_flg;
        out_tag <= s2_q.tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Randomised and directed bench for fp_mult_pipe (fp32) against an exact-integer reference model.
module tb_fp_mult_pipe;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  rm = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] z;
  logic [3:0]  flags;
  logic [3:0]  out_tag;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] z;
    logic [3:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [31:0] z;
    logic [3:0]  f;
  } vec_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [35:0] mon_r;
  logic        prev_stall = 1'b0;
  vec_t        dir[13];

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .rm        (rm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .flags     (flags),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // Exact product of the significands, rounded by comparing the remainder against half an ulp.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] mode);
    int              ex, ey, e, sh, msb;
    longint unsigned n, q, rem, half;
    logic            s, inc, zx, zy, ix, iy, nx, ny;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    zx = (ex == 0);
    zy = (ey == 0);
    if (nx || ny) return {4'b1000, 32'hFFC00000};
    if ((ix && zy) || (iy && zx)) return {4'b1000, 32'hFFC00000};
    if (ix || iy) return {4'b0000, s, 8'hFF, 23'h0};
    if (zx || zy) return {4'b0000, s, 31'h0};
    n   = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    msb = 0;
    for (int i = 0; i < 64; i++) if (n[i]) msb = i;
    sh   = msb - 23;
    q    = n >> sh;
    rem  = n & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    case (mode)
      2'd0:    inc = (rem > half) || ((rem == half) && q[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = (rem != 0) && !s;
      default: inc = (rem != 0) && s;
    endcase
    q = q + 64'(inc);
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      sh = sh + 1;
    end
    e = ex + ey - 127 + sh - 23;
    if (e >= 255) begin
      if (mode == 2'd0 || (mode == 2'd2 && !s) || (mode == 2'd3 && s))
        return {4'b0101, s, 8'hFF, 23'h0};
      return {4'b0101, s, 8'hFE, 23'h7FFFFF};
    end
    if (e < 1) return {4'b0011, s, 31'h0};
    return {3'b000, (rem != 0), s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 7))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 40));
      3:       e = 8'($urandom_range(200, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    f = ($urandom_range(0, 5) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // Single compare process: every valid output is checked against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      sbq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold_out_valid", out_valid, 1);
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=valid tag=%0d z=%h required=idle", out_tag, z);
        end else begin
          mon_e = sbq[0];
          chk("out_z", z, mon_e.z);
          chk("out_flags", flags, mon_e.flags);
          chk("out_tag", out_tag, mon_e.tag);
          if (out_ready) void'(sbq.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      if (in_valid && in_ready) begin
        mon_r = ref_mul(a, b, rm);
        sbq.push_back('{z: mon_r[31:0], flags: mon_r[35:32], tag: in_tag});
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m,
                      input logic [3:0] t);
    int n = 0;
    bit done = 0;
    a = x; b = y; rm = m; in_tag = t; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 500) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=not_accepted required=accepted tag=%0d", t);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  int         lat;
  bit         seen;
  int         nt;
  bit         got;
  int         cyc;
  bit         done_rand;
  logic [35:0] r;

  initial begin
    dir[0]  = '{32'h40400000, 32'h40000000, 2'd0, 32'h40C00000, 4'h0};
    dir[1]  = '{32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'h1};
    dir[2]  = '{32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'h1};
    dir[3]  = '{32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 4'h1};
    dir[4]  = '{32'h7F800000, 32'h00000000, 2'd0, 32'hFFC00000, 4'h8};
    dir[5]  = '{32'h7FC00000, 32'h3F800000, 2'd0, 32'hFFC00000, 4'h8};
    dir[6]  = '{32'h7F000000, 32'h7F000000, 2'd0, 32'h7F800000, 4'h5};
    dir[7]  = '{32'h7F000000, 32'h7F000000, 2'd1, 32'h7F7FFFFF, 4'h5};
    dir[8]  = '{32'h00800000, 32'h3F000000, 2'd0, 32'h00000000, 4'h3};
    dir[9]  = '{32'hFF000000, 32'h7F000000, 2'd3, 32'hFF800000, 4'h5};
    dir[10] = '{32'h80000000, 32'h40000000, 2'd2, 32'h80000000, 4'h0};
    dir[11] = '{32'h7F800000, 32'hBF800000, 2'd0, 32'hFF800000, 4'h0};
    dir[12] = '{32'h00000001, 32'h40000000, 2'd0, 32'h00000000, 4'h0};

    // Pin the reference model to hand-computed results.
    for (int i = 0; i < 13; i++) begin
      r = ref_mul(dir[i].a, dir[i].b, dir[i].rm);
      chk($sformatf("model_z_%0d", i), r[31:0], dir[i].z);
      chk($sformatf("model_flags_%0d", i), r[35:32], dir[i].f);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", z, 0);
    chk("rst_flags", flags, 0);
    chk("rst_out_tag", out_tag, 0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // First-result latency counted in cycles after the transfer cycle.
    send(dir[0].a, dir[0].b, dir[0].rm, 4'd0);
    lat = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("latency", lat, 3);
    @(posedge clk);
    #1;

    for (int i = 1; i < 13; i++) send(dir[i].a, dir[i].b, dir[i].rm, 4'(i));
    wait_drain();

    // Backpressure: tags 1..6 offered back-to-back against a stalled consumer.
    out_ready = 1'b0;
    nt = 1;
    a = rand_op(); b = rand_op(); rm = 2'($urandom); in_tag = 4'(nt); in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) begin
        nt++;
        if (nt <= 6) begin
          a = rand_op(); b = rand_op(); rm = 2'($urandom); in_tag = 4'(nt);
        end else in_valid = 1'b0;
      end
    end
    chk("bp_accepted_while_stalled", nt - 1, 3);
    chk("bp_in_ready_full", in_ready, 0);
    out_ready = 1'b1;
    cyc = 0;
    while (nt <= 6 && cyc < 100) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (got) begin
        nt++;
        if (nt <= 6) begin
          a = rand_op(); b = rand_op(); rm = 2'($urandom); in_tag = 4'(nt);
        end
      end
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", nt, 7);
    wait_drain();

    // Random traffic with random consumer stalls.
    done_rand = 0;
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rand_op(), rand_op(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end
        done_rand = 1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Asynchronous reset with a full, stalled pipeline.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_op(), rand_op(), 2'($urandom), 4'(i + 4));
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_z", z, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(dir[0].a, dir[0].b, dir[0].rm, 4'd9);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
